// File: rtl/branch_predictor_gshare_btb.sv
// branch_predictor_gshare_btb: gshare/bimodal PHT with tagged BTB, speculative GHR and perf counters
module branch_predictor_gshare_btb #(
    parameter int PHT_DEPTH = 1024,
    parameter int CTR_BITS  = 2,
    parameter int HIST_LEN  = 8,
    parameter int BTB_DEPTH = 128,
    parameter int PRED_MODE = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                lk_valid_i,
    input  logic [31:0]         lk_pc_i,
    output logic                pred_taken_o,
    output logic [31:0]         pred_target_o,
    output logic                btb_hit_o,
    output logic [HIST_LEN-1:0] pred_ghr_o,
    input  logic                upd_valid_i,
    input  logic [31:0]         upd_pc_i,
    input  logic                upd_taken_i,
    input  logic [31:0]         upd_target_i,
    input  logic [HIST_LEN-1:0] upd_ghr_i,
    input  logic                upd_mispred_i,
    output logic [31:0]         perf_br_o,
    output logic [31:0]         perf_miss_o
);
    localparam int IDX_W = $clog2(PHT_DEPTH);
    localparam int BI_W  = $clog2(BTB_DEPTH);
    localparam int TAG_W = 30 - BI_W;
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    logic [CTR_BITS-1:0] pht_q [PHT_DEPTH];
    logic [BTB_DEPTH-1:0] btb_v_q;
    logic [TAG_W-1:0]    btb_tag_q [BTB_DEPTH];
    logic [31:0]         btb_tgt_q [BTB_DEPTH];
    logic [HIST_LEN-1:0] ghr_q, ghr_d;
    logic [31:0]         perf_br_q, perf_br_d, perf_miss_q, perf_miss_d;
    logic [IDX_W-1:0]    lk_idx, upd_idx;
    logic [BI_W-1:0]     lk_bi, upd_bi;
    logic [CTR_BITS-1:0] ctr_cur, ctr_d;
    logic                unused_ok;
    assign unused_ok = ^{lk_pc_i[1:0], upd_pc_i[1:0]};
    // Lookup and update indices share one formula; history folds in only in gshare mode
    always_comb begin
        lk_idx        = lk_pc_i[IDX_W+1:2] ^ ((PRED_MODE != 0) ? IDX_W'(ghr_q) : '0);
        upd_idx       = upd_pc_i[IDX_W+1:2] ^ ((PRED_MODE != 0) ? IDX_W'(upd_ghr_i) : '0);
        lk_bi         = lk_pc_i[BI_W+1:2];
        upd_bi        = upd_pc_i[BI_W+1:2];
        btb_hit_o     = btb_v_q[lk_bi] && (btb_tag_q[lk_bi] == lk_pc_i[31:BI_W+2]);
        pred_taken_o  = btb_hit_o && pht_q[lk_idx][CTR_BITS-1];
        pred_target_o = pred_taken_o ? btb_tgt_q[lk_bi] : lk_pc_i + 32'd4;
        pred_ghr_o    = ghr_q;
    end
    // Next-state: saturating counter step, GHR repair over speculative shift, saturating perf counts
    always_comb begin
        ctr_cur     = pht_q[upd_idx];
        ctr_d       = upd_taken_i ? ((ctr_cur == '1) ? ctr_cur : ctr_cur + CTR_BITS'(1))
                                  : ((ctr_cur == '0) ? ctr_cur : ctr_cur - CTR_BITS'(1));
        ghr_d       = (upd_valid_i && upd_mispred_i) ? HIST_LEN'({upd_ghr_i, upd_taken_i})
                    : (lk_valid_i && btb_hit_o)      ? HIST_LEN'({ghr_q, pred_taken_o})
                    : ghr_q;
        perf_br_d   = perf_br_q + 32'(upd_valid_i && (perf_br_q != '1));
        perf_miss_d = perf_miss_q + 32'(upd_valid_i && upd_mispred_i && (perf_miss_q != '1));
    end
    // PHT counters train on every resolved branch
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < PHT_DEPTH; i++) pht_q[i] <= CTR_WNT;
        end else if (upd_valid_i) begin
            pht_q[upd_idx] <= ctr_d;
        end
    end
    // BTB valid bits: only taken branches allocate, overwriting any alias
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btb_v_q <= '0;
        end else if (upd_valid_i && upd_taken_i) begin
            btb_v_q[upd_bi] <= 1'b1;
        end
    end
    // BTB tag/target payload needs no reset; the valid bit guards it
    always_ff @(posedge clk_i) begin
        if (upd_valid_i && upd_taken_i) begin
            btb_tag_q[upd_bi] <= upd_pc_i[31:BI_W+2];
            btb_tgt_q[upd_bi] <= upd_target_i;
        end
    end
    // History register and performance counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ghr_q       <= '0;
            perf_br_q   <= '0;
            perf_miss_q <= '0;
        end else begin
            ghr_q       <= ghr_d;
            perf_br_q   <= perf_br_d;
            perf_miss_q <= perf_miss_d;
        end
    end
    assign perf_br_o   = perf_br_q;
    assign perf_miss_o = perf_miss_q;
endmodule

// File: tb/tb_branch_predictor_gshare_btb.sv
// tb_branch_predictor_gshare_btb: bimodal and gshare instances checked against a table-level model
module tb_branch_predictor_gshare_btb;
    localparam int PD = 1024;
    localparam int BD = 128;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cmp_en = 1'b0;
    logic lk_valid = 1'b0;
    logic [31:0] lk_pc = 32'h40;
    logic upd_valid = 1'b0, upd_taken = 1'b0, upd_mispred = 1'b0;
    logic [31:0] upd_pc = '0, upd_target = '0;
    logic [7:0] upd_ghr = '0;
    logic [1:0] hit, tk;
    logic [1:0][31:0] tgt, pbr, pmiss;
    logic [1:0][7:0] pg;
    int errors = 0;
    int checks = 0;
    int pht [2][PD];
    bit bv [2][BD];
    logic [31:0] btag [2][BD];
    logic [31:0] btgt [2][BD];
    int ghr [2];
    longint mbr, mmiss;

    always #5 clk = ~clk;

    branch_predictor_gshare_btb #(.PRED_MODE(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .lk_valid_i(lk_valid), .lk_pc_i(lk_pc),
        .pred_taken_o(tk[0]), .pred_target_o(tgt[0]), .btb_hit_o(hit[0]), .pred_ghr_o(pg[0]),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
        .upd_target_i(upd_target), .upd_ghr_i(upd_ghr), .upd_mispred_i(upd_mispred),
        .perf_br_o(pbr[0]), .perf_miss_o(pmiss[0]));

    branch_predictor_gshare_btb #(.PRED_MODE(1)) dut_g (
        .clk_i(clk), .rst_i(rst), .lk_valid_i(lk_valid), .lk_pc_i(lk_pc),
        .pred_taken_o(tk[1]), .pred_target_o(tgt[1]), .btb_hit_o(hit[1]), .pred_ghr_o(pg[1]),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
        .upd_target_i(upd_target), .upd_ghr_i(upd_ghr), .upd_mispred_i(upd_mispred),
        .perf_br_o(pbr[1]), .perf_miss_o(pmiss[1]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int midx(int m, logic [31:0] pc, int g);
        return int'((pc >> 2) % PD) ^ ((m == 1) ? g : 0);
    endfunction

    function automatic bit mhit(int m, logic [31:0] pc);
        int b = int'((pc >> 2) % BD);
        return bv[m][b] && (btag[m][b] == pc / (4 * BD));
    endfunction

    function automatic bit mtk(int m, logic [31:0] pc);
        return mhit(m, pc) && (pht[m][midx(m, pc, ghr[m])] >= 2);
    endfunction

    function automatic logic [31:0] mtgt(int m, logic [31:0] pc);
        return mtk(m, pc) ? btgt[m][int'((pc >> 2) % BD)] : pc + 32'd4;
    endfunction

    // Reference model: counters as integers, BTB as plain arrays, GHR as a number mod 256
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < PD; i++) pht[m][i] = 1;
                for (int i = 0; i < BD; i++) bv[m][i] = 1'b0;
                ghr[m] = 0;
            end
            mbr = 0;
            mmiss = 0;
        end else begin
            for (int m = 0; m < 2; m++) begin
                bit sh, st;
                int u, b;
                sh = lk_valid && mhit(m, lk_pc);
                st = mtk(m, lk_pc);
                if (upd_valid) begin
                    u = midx(m, upd_pc, int'(upd_ghr));
                    if (upd_taken) pht[m][u] = (pht[m][u] == 3) ? 3 : pht[m][u] + 1;
                    else pht[m][u] = (pht[m][u] == 0) ? 0 : pht[m][u] - 1;
                    if (upd_taken) begin
                        b = int'((upd_pc >> 2) % BD);
                        bv[m][b] = 1'b1;
                        btag[m][b] = upd_pc / (4 * BD);
                        btgt[m][b] = upd_target;
                    end
                end
                if (upd_valid && upd_mispred) ghr[m] = (int'(upd_ghr) * 2 + int'(upd_taken)) % 256;
                else if (sh) ghr[m] = (ghr[m] * 2 + int'(st)) % 256;
            end
            if (upd_valid) begin
                if (mbr < 64'hFFFF_FFFF) mbr++;
                if (upd_mispred && mmiss < 64'hFFFF_FFFF) mmiss++;
            end
        end
    end

    // Every cycle, both instances against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("hit%0d", m), 32'(hit[m]), 32'(mhit(m, lk_pc)));
                chk($sformatf("taken%0d", m), 32'(tk[m]), 32'(mtk(m, lk_pc)));
                chk($sformatf("target%0d", m), tgt[m], mtgt(m, lk_pc));
                chk($sformatf("ghr%0d", m), 32'(pg[m]), 32'(ghr[m]));
                chk($sformatf("perf_br%0d", m), pbr[m], 32'(mbr));
                chk($sformatf("perf_miss%0d", m), pmiss[m], 32'(mmiss));
            end
        end
    end

    task automatic look(input logic [31:0] pc, input bit v);
        lk_valid = v;
        lk_pc = pc;
        #1;
    endtask

    task automatic su(input logic [31:0] pc, input bit t, input logic [31:0] tg, input logic [7:0] g, input bit mp);
        upd_valid = 1'b1;
        upd_pc = pc;
        upd_taken = t;
        upd_target = tg;
        upd_ghr = g;
        upd_mispred = mp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        lk_valid = 1'b0;
        upd_valid = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input bit t, input logic [31:0] tg, input logic [7:0] g, input bit mp);
        su(pc, t, tg, g, mp);
        tick();
    endtask

    initial begin
        logic [7:0] snap;
        bit ptk, act;
        #1 rst = 1'b1;
        cmp_en = 1'b1;
        tick();
        look(32'h40, 0);
        for (int m = 0; m < 2; m++) begin
            chk("rst_hit", 32'(hit[m]), 0);
            chk("rst_taken", 32'(tk[m]), 0);
            chk("rst_target", tgt[m], 32'h44);
            chk("rst_perf_br", pbr[m], 0);
            chk("rst_perf_miss", pmiss[m], 0);
        end
        rst = 1'b0;
        repeat (2) upd(32'h40, 1, 32'h80, 8'h00, 0);
        look(32'h40, 0);
        for (int m = 0; m < 2; m++) begin
            chk("bim_taken", 32'(tk[m]), 1);
            chk("bim_target", tgt[m], 32'h80);
        end
        repeat (2) upd(32'h40, 0, 32'h0, 8'h00, 0);
        look(32'h40, 0);
        for (int m = 0; m < 2; m++) begin
            chk("bim_nt", 32'(tk[m]), 0);
            chk("bim_nt_target", tgt[m], 32'h44);
            chk("bim_still_hit", 32'(hit[m]), 1);
        end
        repeat (5) upd(32'h40, 1, 32'h80, 8'h00, 0);
        upd(32'h40, 0, 32'h0, 8'h00, 0);
        look(32'h40, 0);
        for (int m = 0; m < 2; m++) chk("sat_hi", 32'(tk[m]), 1);
        repeat (5) upd(32'h40, 0, 32'h0, 8'h00, 0);
        upd(32'h40, 1, 32'h80, 8'h00, 0);
        look(32'h40, 0);
        for (int m = 0; m < 2; m++) begin
            chk("sat_lo", 32'(tk[m]), 0);
            chk("perf_br16", pbr[m], 16);
            chk("perf_miss0", pmiss[m], 0);
        end
        for (int i = 0; i < 24; i++) begin
            act = (i % 2 == 0);
            look(32'h100, 1);
            snap = pg[1];
            ptk = tk[1];
            if (i >= 20) chk($sformatf("gshare_phase%0d", i), 32'(ptk), 32'(act));
            tick();
            upd(32'h100, act, 32'h200, snap, ptk != act);
        end
        upd(32'h100, 0, 32'h0, 8'h5A, 1);
        for (int m = 0; m < 2; m++) chk("repair_ghr", 32'(pg[m]), 32'hB4);
        lk_valid = 1'b1;
        lk_pc = 32'h100;
        upd(32'h100, 1, 32'h200, 8'h33, 1);
        for (int m = 0; m < 2; m++) chk("repair_prio", 32'(pg[m]), 32'h67);
        look(32'h40, 0);
        su(32'h40, 1, 32'h80, 8'h00, 0);
        #1;
        chk("rbw_old_ctr", 32'(tk[0]), 0);
        tick();
        chk("rbw_new_ctr", 32'(tk[0]), 1);
        chk("rbw_new_tgt", tgt[0], 32'h80);
        look(32'h300, 0);
        su(32'h300, 1, 32'h400, 8'h00, 0);
        #1;
        for (int m = 0; m < 2; m++) chk("rbw_btb_old", 32'(hit[m]), 0);
        tick();
        for (int m = 0; m < 2; m++) chk("rbw_btb_new", 32'(hit[m]), 1);
        chk("rbw_btb_tgt", tgt[0], 32'h400);
        upd(32'h240, 1, 32'h500, 8'h00, 0);
        look(32'h40, 0);
        for (int m = 0; m < 2; m++) begin
            chk("alias_evict", 32'(hit[m]), 0);
            chk("alias_evict_tgt", tgt[m], 32'h44);
        end
        look(32'h240, 0);
        for (int m = 0; m < 2; m++) chk("alias_hit", 32'(hit[m]), 1);
        chk("alias_taken", 32'(tk[0]), 1);
        chk("alias_tgt", tgt[0], 32'h500);
        look(32'h240, 1);
        su(32'h100, 1, 32'h200, 8'h00, 1);
        rst = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("midrst_hit", 32'(hit[m]), 0);
            chk("midrst_tgt", tgt[m], 32'h244);
            chk("midrst_perf", pbr[m], 0);
        end
        tick();
        rst = 1'b0;
        for (int m = 0; m < 2; m++) begin
            look(32'h240, 0);
            chk("post_rst_240", 32'(hit[m]), 0);
            look(32'h100, 0);
            chk("post_rst_100", 32'(hit[m]), 0);
            look(32'h300, 0);
            chk("post_rst_300", 32'(hit[m]), 0);
            chk("post_rst_ghr", 32'(pg[m]), 0);
            chk("post_rst_br", pbr[m], 0);
            chk("post_rst_miss", pmiss[m], 0);
        end
        upd(32'h240, 1, 32'h500, 8'h00, 0);
        look(32'h240, 0);
        for (int m = 0; m < 2; m++) begin
            chk("post_rst_train", 32'(tk[m]), 1);
            chk("post_rst_tgt", tgt[m], 32'h500);
        end
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
